// File: rtl/miter_checker_pkg.sv
//============================================================================
// Module      : miter_checker_pkg
// Description : Shared types and constants for the miter sweep checker.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package miter_checker_pkg;

    // Deepest supported trigger latency; sizes the drain counter.
    localparam int LAT_MAX = 7;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/miter_addr_pipe.sv
//============================================================================
// Module      : miter_addr_pipe
// Description : LAT-deep delay line carrying an issued address and its valid
//               bit, so each returning trigger can be matched to the address
//               that caused it. LAT=0 is a plain wire-through.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module miter_addr_pipe #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_valid
);

    generate
        if (LAT == 0) begin : g_wire
            // Clock and reset have no role without storage.
            logic w_unused_ctl;
            assign w_unused_ctl = clk ^ rst;
            assign o_addr       = i_addr;
            assign o_valid      = i_valid;
        end else begin : g_pipe
            logic [ADDR_W-1:0] r_addr [LAT];
            logic [LAT-1:0]    r_valid;

            // Shift address and valid one stage per cycle; reset empties the line.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_addr[i]  <= '0;
                        r_valid[i] <= 1'b0;
                    end
                end else begin
                    r_addr[0]  <= i_addr;
                    r_valid[0] <= i_valid;
                    for (int i = 1; i < LAT; i++) begin
                        r_addr[i]  <= r_addr[i-1];
                        r_valid[i] <= r_valid[i-1];
                    end
                end
            end

            assign o_addr  = r_addr[LAT-1];
            assign o_valid = r_valid[LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/miter_checker.sv
//============================================================================
// Module      : miter_checker
// Description : Sweeps every address into a miter, counts returning mismatch
//               triggers (saturating) and reports pass/fail at the end.
//               Optional macro MITER_CHECKER_FIRSTERR_EN enables capture of
//               the first mismatching address; otherwise those ports are 0.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module miter_checker
    import miter_checker_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              in_trigger,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid
);

    localparam logic [ADDR_W-1:0]    c_addr_last  = '1;
    localparam logic [CNT_W-1:0]     c_cnt_max    = '1;
    localparam int                   c_drain_w    = $clog2(LAT_MAX + 1);
    localparam logic [c_drain_w-1:0] c_drain_last = (LAT > 0) ? c_drain_w'(LAT - 1) : '0;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_W-1:0]      r_addr;
    logic [c_drain_w-1:0]   r_drain_cnt;
    logic [CNT_W-1:0]       r_err;

    logic                   w_issue;
    logic                   w_last;
    logic                   w_accept;
    logic [ADDR_W-1:0]      w_dly_addr;
    logic                   w_dly_valid;
    logic                   w_sample;

    // Only addresses shown during SWEEP are real stimulus; fill and drain
    // cycles carry an invalid tag so stray triggers are ignored.
    assign w_issue  = (r_state == ST_SWEEP);
    assign w_last   = (r_addr == c_addr_last);
    assign w_accept = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_sample = w_dly_valid & in_trigger;

    miter_addr_pipe #(
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (r_addr),
        .i_valid (w_issue),
        .o_addr  (w_dly_addr),
        .o_valid (w_dly_valid)
    );

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (w_last) w_state_nxt = (LAT == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == c_drain_last) w_state_nxt = ST_DONE;
            ST_DONE:  if (start)  w_state_nxt = ST_SWEEP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Address generator: restart at 0, count up through SWEEP, then hold.
    always_ff @(posedge clk) begin
        if (rst)                                 r_addr <= '0;
        else if (w_accept)                       r_addr <= '0;
        else if (w_issue && !w_last)             r_addr <= r_addr + 1'b1;
    end

    // Drain counter measures the LAT cycles left for in-flight triggers.
    always_ff @(posedge clk) begin
        if (rst)                       r_drain_cnt <= '0;
        else if (r_state == ST_DRAIN)  r_drain_cnt <= r_drain_cnt + 1'b1;
        else                           r_drain_cnt <= '0;
    end

    // Saturating mismatch counter, cleared at the start of each sweep.
    always_ff @(posedge clk) begin
        if (rst)                                 r_err <= '0;
        else if (w_accept)                       r_err <= '0;
        else if (w_sample && r_err != c_cnt_max) r_err <= r_err + 1'b1;
    end

`ifdef MITER_CHECKER_FIRSTERR_EN
    logic [ADDR_W-1:0] r_first_addr;
    logic              r_first_valid;

    // Latch the address of the first sampled mismatch of a sweep only.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_first_addr  <= '0;
            r_first_valid <= 1'b0;
        end else if (w_sample && !r_first_valid) begin
            r_first_addr  <= w_dly_addr;
            r_first_valid <= 1'b1;
        end
    end

    assign first_err_addr  = r_first_addr;
    assign first_err_valid = r_first_valid;
`else
    // Delayed address only feeds first-error capture.
    logic w_unused_dly_addr;
    assign w_unused_dly_addr = ^w_dly_addr;
    assign first_err_addr    = '0;
    assign first_err_valid   = 1'b0;
`endif

    assign out_addr  = r_addr;
    assign busy      = (r_state == ST_SWEEP) | (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign pass      = (r_state == ST_DONE) & (r_err == '0);
    assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_miter_checker.sv
//============================================================================
// Module      : tb_miter_checker
// Description : Self-checking bench for miter_checker. Three instances run
//               side by side: defaults, CNT_W=4, and LAT=0. A timeline model
//               (cycles since the accepted start) predicts every output.
//               Edge numbering for done: the edge that samples start is 1.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_miter_checker;

    localparam int N = 256;
`ifdef MITER_CHECKER_FIRSTERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, start_v, trig_v;
    logic [2:0] busy_v, done_v, pass_v, fv_v;
    logic [7:0] oa0, oa1, oa2, fa0, fa1, fa2;
    logic [8:0] ec0, ec2;
    logic [3:0] ec1;

    miter_checker #(.ADDR_W(8), .CNT_W(9), .LAT(1)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .out_addr(oa0),
        .in_trigger(trig_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(ec0), .first_err_addr(fa0), .first_err_valid(fv_v[0]));

    miter_checker #(.ADDR_W(8), .CNT_W(4), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .out_addr(oa1),
        .in_trigger(trig_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(ec1), .first_err_addr(fa1), .first_err_valid(fv_v[1]));

    miter_checker #(.ADDR_W(8), .CNT_W(9), .LAT(0)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .out_addr(oa2),
        .in_trigger(trig_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(ec2), .first_err_addr(fa2), .first_err_valid(fv_v[2]));

    int oa_a [3];
    int ec_a [3];
    int fa_a [3];
    assign oa_a[0] = int'(oa0);
    assign oa_a[1] = int'(oa1);
    assign oa_a[2] = int'(oa2);
    assign ec_a[0] = int'(ec0);
    assign ec_a[1] = int'(ec1);
    assign ec_a[2] = int'(ec2);
    assign fa_a[0] = int'(fa0);
    assign fa_a[1] = int'(fa1);
    assign fa_a[2] = int'(fa2);

    // Per-instance configuration and trigger pattern
    // (0 none, 1 at 0x37, 2 always high, 3 at 0xFF).
    int lat_p  [3] = '{1, 1, 0};
    int cmax_p [3] = '{511, 15, 511};
    int mode   [3] = '{0, 0, 0};

    // Timeline model: t = cycles since the accepted start.
    bit m_started [3] = '{0, 0, 0};
    int m_t       [3] = '{0, 0, 0};
    int m_err     [3] = '{0, 0, 0};
    bit m_fv      [3] = '{0, 0, 0};
    int m_fa      [3] = '{0, 0, 0};

    int  done_at   [3] = '{0, 0, 0};
    bit  prev_done [3] = '{0, 0, 0};
    bit  chk_on = 1'b0;
    int  n_checks = 0;
    int  n_err    = 0;

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, id, act, exp, $time);
        end
    endtask

    // Address whose trigger is sampled this cycle, or -1 when none is.
    function automatic int samp(input int id);
        int idx;
        if (!m_started[id]) return -1;
        idx = m_t[id] - lat_p[id];
        return (idx >= 0 && idx < N) ? idx : -1;
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                m_started[i] = 1'b0; m_t[i] = 0; m_err[i] = 0; m_fv[i] = 1'b0; m_fa[i] = 0;
            end else if (start_v[i] && (!m_started[i] || m_t[i] >= N + lat_p[i])) begin
                m_started[i] = 1'b1; m_t[i] = 0; m_err[i] = 0; m_fv[i] = 1'b0; m_fa[i] = 0;
            end else if (m_started[i]) begin
                if (samp(i) >= 0 && trig_v[i]) begin
                    if (m_err[i] < cmax_p[i]) m_err[i]++;
                    if (!m_fv[i]) begin m_fv[i] = 1'b1; m_fa[i] = samp(i); end
                end
                if (m_t[i] < 100000) m_t[i]++;
            end
        end
    end

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                int  e_oa;
                bit  e_busy, e_done;
                e_oa   = !m_started[i] ? 0 : (m_t[i] < N ? m_t[i] : N - 1);
                e_busy = m_started[i] && (m_t[i] < N + lat_p[i]);
                e_done = m_started[i] && (m_t[i] >= N + lat_p[i]);
                chk("out_addr",  i, oa_a[i],          e_oa);
                chk("busy",      i, int'(busy_v[i]),  int'(e_busy));
                chk("done",      i, int'(done_v[i]),  int'(e_done));
                chk("pass",      i, int'(pass_v[i]),  int'(e_done && m_err[i] == 0));
                chk("err_count", i, ec_a[i],          m_err[i]);
                chk("first_v",   i, int'(fv_v[i]),    FE ? int'(m_fv[i]) : 0);
                chk("first_a",   i, fa_a[i],          FE ? m_fa[i] : 0);
                if (done_v[i] && !prev_done[i]) done_at[i] = m_t[i] + 1;
                prev_done[i] = done_v[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            case (mode[i])
                1:       trig_v[i] = (samp(i) == 8'h37);
                2:       trig_v[i] = 1'b1;
                3:       trig_v[i] = (samp(i) == 8'hFF);
                default: trig_v[i] = 1'b0;
            endcase
        end
    endtask

    task automatic wait_done(input logic [2:0] mask, input string name);
        int k;
        k = 0;
        while (((done_v & mask) != mask) && k < 400) begin
            tick();
            k++;
        end
        chk(name, 0, int'((done_v & mask) == mask), 1);
    endtask

    initial begin
        rst_v = 3'b111; start_v = 3'b000; trig_v = 3'b000;
        tick(); tick();
        chk_on = 1'b1;
        rst_v = 3'b000;
        tick();
        chk("reset_addr", 0, int'(oa0), 0);
        chk("reset_done", 2, int'(done_v[2]), 0);

        // All three sweep together with different trigger patterns.
        mode = '{1, 2, 3};
        done_at = '{0, 0, 0};
        start_v = 3'b111;
        tick();
        start_v = 3'b000;
        repeat (100) tick();
        start_v = 3'b101;            // must be ignored mid-sweep
        tick();
        start_v = 3'b000;
        wait_done(3'b111, "sweep1_timeout");
        repeat (3) tick();
        chk("d0_done_edge", 0, done_at[0], 258);
        chk("d0_err",       0, int'(ec0), 1);
        chk("d0_pass",      0, int'(pass_v[0]), 0);
        chk("d0_first_a",   0, int'(fa0), FE ? 8'h37 : 0);
        chk("d0_first_v",   0, int'(fv_v[0]), FE ? 1 : 0);
        chk("d1_err_sat",   1, int'(ec1), 15);
        chk("d1_pass",      1, int'(pass_v[1]), 0);
        chk("d2_done_edge", 2, done_at[2], 257);
        chk("d2_err",       2, int'(ec2), 1);
        chk("d2_first_a",   2, int'(fa2), FE ? 8'hFF : 0);

        // Clean restart from DONE.
        mode = '{0, 2, 3};
        done_at[0] = 0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("restart_addr", 0, int'(oa0), 0);
        chk("restart_err",  0, int'(ec0), 0);
        wait_done(3'b001, "sweep2_timeout");
        tick();
        chk("d0_clean_edge", 0, done_at[0], 258);
        chk("d0_clean_pass", 0, int'(pass_v[0]), 1);
        chk("d0_clean_err",  0, int'(ec0), 0);
        chk("d0_clean_fv",   0, int'(fv_v[0]), 0);

        // Reset in the middle of a sweep, then a full fresh sweep.
        mode[0] = 2;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        begin
            int k;
            k = 0;
            while (oa0 != 8'h80 && k < 300) begin tick(); k++; end
            chk("reach_0x80", 0, int'(oa0), 8'h80);
        end
        rst_v[0] = 1'b1;
        start_v[0] = 1'b1;           // reset wins
        tick();
        rst_v[0] = 1'b0;
        start_v[0] = 1'b0;
        chk("mid_rst_addr", 0, int'(oa0), 0);
        chk("mid_rst_busy", 0, int'(busy_v[0]), 0);
        chk("mid_rst_err",  0, int'(ec0), 0);
        chk("mid_rst_done", 0, int'(done_v[0]), 0);
        mode[0] = 0;
        tick();
        done_at[0] = 0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_done(3'b001, "sweep3_timeout");
        tick();
        chk("d0_after_rst_edge", 0, done_at[0], 258);
        chk("d0_after_rst_pass", 0, int'(pass_v[0]), 1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/miter_checker.md
MITER_CHECKER -- requirements
Module: miter_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the stimulus address width; sweep length N = 2^ADDR_W.
REQ-002 SHALL have parameter CNT_W, default 9, giving the error counter width.
REQ-003 SHALL have parameter LAT, default 1, legal 0..7, giving cycles from out_addr to the matching in_trigger.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a sweep.
REQ-007 SHALL have port out_addr  output  ADDR_W  address driven into the miter in_A.
REQ-008 SHALL have port in_trigger  input  1  miter mismatch flag for the address issued LAT cycles earlier.
REQ-009 SHALL have port busy  output  1  high in SWEEP and DRAIN.
REQ-010 SHALL have port done  output  1  high in DONE.
REQ-011 SHALL have port pass  output  1  high in DONE when err_count == 0.
REQ-012 SHALL have port err_count  output  CNT_W  saturating mismatch count.
REQ-013 SHALL have port first_err_addr  output  ADDR_W  address of the first mismatch.
REQ-014 SHALL have port first_err_valid  output  1  first_err_addr holds a captured value.

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, DRAIN, DONE.
REQ-016 IDLE: start=1 -> SWEEP; err_count, first_err_* cleared on that edge; out_addr=0 in the next cycle.
REQ-017 SWEEP: out_addr increments by 1 per cycle; the cycle showing out_addr=N-1 -> DRAIN (LAT>0) or DONE (LAT=0).
REQ-018 DRAIN: lasts exactly LAT cycles, then -> DONE.
REQ-019 Each issued address SHALL travel with a valid bit through a LAT-deep delay line; in_trigger is sampled only when the delayed valid bit is 1 and is ignored otherwise (IDLE, DONE, pipeline fill).
REQ-020 LAT=0: in_trigger SHALL be sampled in the same cycle as out_addr.
REQ-021 Sampled in_trigger=1 SHALL increment err_count, saturating at 2^CNT_W-1 with no wrap.
REQ-022 done SHALL first be high 2^ADDR_W+LAT+1 rising edges after the edge that samples start (258 for defaults).
REQ-023 DONE: outputs held; start=1 -> SWEEP with the same clearing as REQ-016.
REQ-024 start in SWEEP or DRAIN SHALL be ignored.
REQ-025 out_addr SHALL hold 0 in IDLE and hold its last value in DRAIN and DONE.
REQ-026 pass SHALL be 0 outside DONE.

Reset
REQ-027 rst=1 SHALL force IDLE, clear the delay line, and set every output to 0 on the next edge, in any state including mid-sweep; rst has priority over start.

Configuration
REQ-028 Macro MITER_CHECKER_FIRSTERR_EN defined: the first sampled mismatch of a sweep SHALL load first_err_addr with its delayed address and set first_err_valid; later mismatches do not overwrite it.
REQ-029 Macro undefined: first_err_addr and first_err_valid SHALL be constant 0, ports retained, no capture logic.

Structure
REQ-030 Package miter_checker_pkg SHALL hold the FSM state enum typedef and the constant LAT_MAX = 7.
REQ-031 Sub-module miter_addr_pipe SHALL implement the LAT-deep address+valid delay line, with LAT=0 a wire-through.

Verification
REQ-032 Defaults, in_trigger held 0, start pulse -> done at edge 258, pass=1, err_count=0, first_err_valid=0.
REQ-033 in_trigger high only when the sampled delayed address is 0x37 -> err_count=1, pass=0, first_err_addr=0x37, first_err_valid=1 (with macro).
REQ-034 CNT_W=4, in_trigger held 1 -> err_count stops at 15 and does not wrap; pass=0.
REQ-035 rst pulsed while out_addr=0x80 -> next cycle all outputs 0, state IDLE; a following start runs a full 256-address sweep.
REQ-036 LAT=0, mismatch at 0xFF, start pulsed again mid-sweep -> second start ignored, err_count=1, first_err_addr=0xFF, done at edge 257.
